data_packer_param: RTL and testbench
====================================

Name: data_packer_param

Overview:
- Parametrised successor to the fixed 16-to-128 packer.
- Pulls IN_W-bit words from an upstream FIFO using the empty/enable read interface, with 1-cycle read latency.
- Assembles RATIO words into one OUT_W beat, presented downstream on a valid/ready handshake.
- Adds selectable lane order, a two-deep (pack buffer + output register) pipeline for full throughput under backpressure, and a flush that emits a partial beat with a lane count.

Parameters:
- IN_W, 16: input word width.
- RATIO, 8: words per output beat; must be >= 2.
- MSB_FIRST, 0: 0 puts the first word in lane 0 (bits IN_W-1:0); 1 puts the first word in the top lane.
- OUT_W, IN_W*RATIO: derived; not overridable.
- CNT_W, $clog2(RATIO+1): derived.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- empty  in  1  upstream FIFO empty.
- data_in  in  IN_W  FIFO read data; valid the cycle after enable was high.
- enable  out  1  FIFO read enable.
- flush  in  1  single-cycle pulse requesting emission of a partial beat.
- valid  out  1  output beat valid.
- ready  in  1  downstream accept.
- data_out  out  OUT_W  packed beat.
- lanes  out  CNT_W  number of valid lanes in data_out (1..RATIO).

Behaviour:
- Reset values: valid=0, enable=0, data_out=0, lanes=0. Pack count, pending-read flag and flush request all clear.
- Reset asserted mid-packet discards all partial data; the next packet starts at lane 0.
- State:
  - cnt: words held in the pack buffer.
  - pend: read issued last cycle.
  - freq: sticky flush request.
- enable = !empty && !freq && (cnt + pend < RATIO).
  - Back-to-back reads are allowed.
  - A FIFO read is never issued unless a lane is reserved for the returning word.
- Capture: when pend=1, data_in is written to lane cnt (or RATIO-1-cnt if MSB_FIRST), and cnt increments.
- Transfer to output register happens when (!valid || ready) and either condition holds:
  - the buffer is full, including the word being captured this edge (bypass merge); or
  - freq=1, pend=0, and cnt>0.
- On transfer:
  - unfilled lanes are zero;
  - lanes=cnt (RATIO when full);
  - valid=1;
  - cnt is cleared; freq is cleared if set.
- Latency: valid rises in cycle t+2, where t is the cycle enable was high for the last word of the beat.
- Hold rules:
  - Output hold: while valid && !ready, data_out and lanes are stable.
  - valid drops after a handshake unless a new transfer happens on the same edge.
  - Sustained throughput is 1 beat per RATIO cycles.
- Full pipeline: output register held and cnt==RATIO → enable=0 until ready.
- Flush:
  - flush sets freq, which blocks new reads.
  - A word already in flight is captured and included in the partial beat.
  - freq with cnt==0 and pend==0 clears with no beat.
  - flush arriving when cnt reaches RATIO yields a normal full beat (lanes=RATIO).
  - flush while freq is already set is ignored.
- empty toggling between words inserts gaps only; there are no spurious captures.

Optional Feature:
- Macro PACKER_STATS_EN.
- When defined, adds ports beat_cnt out 32 and stall_cnt out 32, both reset to 0:
  - beat_cnt increments per handshake (valid&&ready);
  - stall_cnt increments per cycle of valid&&!ready;
  - both wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package data_packer_pkg holds:
  - lane-order localparams LANE_LSB_FIRST=0 and LANE_MSB_FIRST=1;
  - a function computing the physical lane index from (count, order, ratio).
- Natural sub-module packer_out_stage: an OUT_W+CNT_W valid/ready output register with load, hold and handshake logic.
  - The packer top owns the read control, pack buffer and flush logic.

Test Plan:
1. Defaults; FIFO holds 0..7; ready=1.
   → enable high 8 consecutive cycles; one beat data_out={16'd7,16'd6,...,16'd0}, lanes=8; valid high 2 cycles after the last enable.
2. MSB_FIRST=1; same stimulus.
   → data_out={16'd0,16'd1,...,16'd7}, lanes=8.
3. ready=0; FIFO holds 16 words 0..15.
   → first beat held stable; enable low after the 16th read; ready=1 gives beats {7..0} then {15..8} on consecutive cycles.
4. Words A5A5, 1234, BEEF, then flush.
   → data_out={80'h0,16'hBEEF,16'h1234,16'hA5A5}, lanes=3.
   → a second flush with the buffer empty produces no beat.
5. empty=1 for 5 cycles after the 4th word, then words 4..7.
   → enable=0 during the gap; final beat {7..0} correct.
6. rst_n low after 5 words captured.
   → valid=0, enable=0, lanes=0, data_out=0; a subsequent 8-word stream 8..15 gives {15..8}.

Source files
------------

// File: rtl/data_packer_pkg.sv
// Shared lane-order constants and lane-index helper for the parametrised word packer.
package data_packer_pkg;

  localparam int unsigned LANE_LSB_FIRST = 0;
  localparam int unsigned LANE_MSB_FIRST = 1;

  // Physical lane that receives the count-th word of a beat.
  function automatic int unsigned lane_index(input int unsigned count,
                                             input int unsigned order,
                                             input int unsigned ratio);
    return (order == LANE_MSB_FIRST) ? (ratio - 1 - count) : count;
  endfunction

endpackage

// File: rtl/packer_out_stage.sv
// Single valid/ready output register: loads a new beat, holds it under backpressure.
module packer_out_stage
  import data_packer_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             free_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/data_packer_param.sv
// Packs RATIO FIFO words into one OUT_W beat with flush of partial beats.
// Optional PACKER_STATS_EN adds beat_cnt/stall_cnt handshake counters.
module data_packer_param
  import data_packer_pkg::*;
#(
  parameter  int unsigned IN_W      = 16,
  parameter  int unsigned RATIO     = 8,
  parameter  int unsigned MSB_FIRST = LANE_LSB_FIRST,
  localparam int unsigned OUT_W     = IN_W * RATIO,
  localparam int unsigned CNT_W     = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  input  logic [IN_W-1:0]  data_in,
  output logic             enable,
  input  logic             flush,
  output logic             valid,
  input  logic             ready,
  output logic [OUT_W-1:0] data_out,
  output logic [CNT_W-1:0] lanes
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]      beat_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam logic [CNT_W:0]   RatioOcc = (CNT_W + 1)'(RATIO);
  localparam logic [CNT_W-1:0] RatioCnt = CNT_W'(RATIO);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cap;
  logic             pend_q, pend_d;
  logic             freq_q, freq_d;
  logic [OUT_W-1:0] buf_q, buf_d, merged;
  logic [CNT_W:0]   occ;
  logic             full, flush_go, load, out_free;
  int unsigned      lane;

  always_comb begin
    occ    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    // Only read when a lane is free for the word that comes back next cycle.
    enable = rst_n && !empty && !freq_q && (occ < RatioOcc);

    lane   = lane_index(32'(cnt_q), MSB_FIRST, RATIO);
    merged = buf_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (pend_q && (i == lane)) merged[i*IN_W +: IN_W] = data_in;
    end
    cnt_cap  = cnt_q + {{(CNT_W-1){1'b0}}, pend_q};

    full     = (cnt_cap == RatioCnt);
    flush_go = freq_q && !pend_q && (cnt_q != '0);
    load     = out_free && (full || flush_go);

    pend_d = enable;
    if (load) begin
      cnt_d  = '0;
      buf_d  = '0;
      freq_d = 1'b0;
    end else begin
      cnt_d  = cnt_cap;
      buf_d  = merged;
      // A request with nothing buffered or in flight retires without a beat.
      freq_d = freq_q ? !((cnt_q == '0) && !pend_q) : flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      freq_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      freq_q <= freq_d;
      buf_q  <= buf_d;
    end
  end

  packer_out_stage #(
    .Width (OUT_W + CNT_W)
  ) u_out_stage (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (load),
    .data_i  ({cnt_cap, merged}),
    .ready_i (ready),
    .free_o  (out_free),
    .valid_o (valid),
    .data_o  ({lanes, data_out})
  );

`ifdef PACKER_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid && ready)  beat_cnt_d  = beat_cnt_q + 32'd1;
    if (valid && !ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_packer_param.sv
// Bench for data_packer_param: LSB-first and MSB-first instances against a word-queue model.
module tb_data_packer_param;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned RATIO = 8;
  localparam int unsigned OUT_W = 128;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [CNT_W-1:0] n;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             ready = 1'b1;
  logic             empty;
  logic [IN_W-1:0]  data_in = '0;
  logic             enable_l, enable_m, valid_l, valid_m;
  logic [OUT_W-1:0] dout_l, dout_m;
  logic [CNT_W-1:0] lanes_l, lanes_m;
`ifdef PACKER_STATS_EN
  logic [31:0]      beat_cnt_l, stall_cnt_l, beat_cnt_m, stall_cnt_m;
`endif

  // Upstream FIFO model
  logic [IN_W-1:0]  mem [0:255];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             pop_req = 1'b0;
  assign empty = (rd_ptr == wr_ptr);

  data_packer_param #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .empty(empty), .data_in(data_in), .enable(enable_l),
    .flush(flush), .valid(valid_l), .ready(ready), .data_out(dout_l), .lanes(lanes_l)
`ifdef PACKER_STATS_EN
    , .beat_cnt(beat_cnt_l), .stall_cnt(stall_cnt_l)
`endif
  );

  data_packer_param #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .empty(empty), .data_in(data_in), .enable(enable_m),
    .flush(flush), .valid(valid_m), .ready(ready), .data_out(dout_m), .lanes(lanes_m)
`ifdef PACKER_STATS_EN
    , .beat_cnt(beat_cnt_m), .stall_cnt(stall_cnt_m)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pop_req) begin
      data_in <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_l = 0;
  int n_m = 0;
  int hs_total = 0;
  int stall_total = 0;
  int en_cyc [0:255];
  int start_l [0:31];
  int hs_l [0:31];
  logic [OUT_W-1:0] got_l [0:31];
  logic [OUT_W-1:0] got_m [0:31];
  logic [CNT_W-1:0] gotn_l [0:31];
  logic [CNT_W-1:0] gotn_m [0:31];
  logic new_l = 1'b1;
  beat_t exp_l[$];
  beat_t exp_m[$];
  logic [IN_W-1:0] pkt[$];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Words arrive in FIFO order; word i of a beat lands in lane i (LSB-first) or RATIO-1-i.
  task automatic close_pkt();
    beat_t bl, bm;
    bl = '0;
    bm = '0;
    for (int i = 0; i < pkt.size(); i++) begin
      bl.d[i*IN_W +: IN_W]             = pkt[i];
      bm.d[(RATIO-1-i)*IN_W +: IN_W]   = pkt[i];
    end
    bl.n = CNT_W'(pkt.size());
    bm.n = bl.n;
    exp_l.push_back(bl);
    exp_m.push_back(bm);
    pkt.delete();
  endtask

  // Model + compare, evaluated mid-cycle when all inputs and outputs are settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pkt.delete();
      exp_l.delete();
      exp_m.delete();
      new_l   = 1'b1;
      pop_req = 1'b0;
    end else begin
      if (valid_l) begin
        if (exp_l.size() == 0) chk("spurious_valid_l", 1, 0);
        else begin
          chk("data_l", dout_l, exp_l[0].d);
          chk("lanes_l", lanes_l, exp_l[0].n);
          if (new_l) begin
            start_l[n_l] = cyc;
            new_l = 1'b0;
          end
          if (ready) begin
            hs_l[n_l]   = cyc;
            got_l[n_l]  = dout_l;
            gotn_l[n_l] = lanes_l;
            n_l++;
            hs_total++;
            new_l = 1'b1;
            void'(exp_l.pop_front());
          end else stall_total++;
        end
      end
      if (valid_m) begin
        if (exp_m.size() == 0) chk("spurious_valid_m", 1, 0);
        else begin
          chk("data_m", dout_m, exp_m[0].d);
          chk("lanes_m", lanes_m, exp_m[0].n);
          if (ready) begin
            got_m[n_m]  = dout_m;
            gotn_m[n_m] = lanes_m;
            n_m++;
            void'(exp_m.pop_front());
          end
        end
      end
      pop_req = enable_l;
      if (enable_l) begin
        en_cyc[rd_ptr] = cyc;
        pkt.push_back(mem[rd_ptr]);
        if (pkt.size() == RATIO) close_pkt();
      end
      if (flush && pkt.size() > 0) close_pkt();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IN_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_beats(input int target, input string name);
    int t = 0;
    while ((n_l < target || n_m < target) && t < 300) begin
      step(1);
      t++;
    end
    chk(name, (n_l >= target) && (n_m >= target), 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  initial begin
    // Reset with words already waiting: no reads while reset is held.
    for (int i = 0; i < 8; i++) push(16'(i));
    step(3);
    chk("rst_valid", valid_l, 0);
    chk("rst_enable", enable_l, 0);
    chk("rst_data", dout_l, 0);
    chk("rst_lanes", lanes_l, 0);
`ifdef PACKER_STATS_EN
    chk("rst_beat_cnt", beat_cnt_l, 0);
`endif
    rst_n = 1'b1;

    // Full beat, both lane orders, latency and back-to-back reads
    wait_beats(1, "t1_beat");
    chk("t1_data_l", got_l[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("t1_lanes_l", gotn_l[0], 8);
    chk("t2_data_m", got_m[0], 128'h0000_0001_0002_0003_0004_0005_0006_0007);
    chk("t2_lanes_m", gotn_m[0], 8);
    chk("t1_en_consecutive", en_cyc[7] - en_cyc[0], 7);
    chk("t1_latency", start_l[0] - en_cyc[7], 2);

    // Backpressure: 17 words queued, only 16 may be read while held
    ready = 1'b0;
    for (int i = 0; i < 17; i++) push(16'(i));
    step(40);
    chk("t3_enable_stalled", enable_l, 0);
    chk("t3_reads", rd_ptr, 24);
    chk("t3_valid_held", valid_l, 1);
    ready = 1'b1;
    wait_beats(3, "t3_beats");
    chk("t3_first", got_l[1], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("t3_second", got_l[2], 128'h000f_000e_000d_000c_000b_000a_0009_0008);
    chk("t3_back_to_back", start_l[2], hs_l[1] + 1);
    step(5);
    pulse_flush();
    wait_beats(4, "t3_leftover");
    chk("t3_leftover_l", got_l[3], 128'h10);
    chk("t3_leftover_n", gotn_l[3], 1);

    // Partial flush, then a flush with nothing buffered
    push(16'hA5A5);
    push(16'h1234);
    push(16'hBEEF);
    step(6);
    pulse_flush();
    wait_beats(5, "t4_beat");
    chk("t4_data_l", got_l[4], {80'h0, 16'hBEEF, 16'h1234, 16'hA5A5});
    chk("t4_lanes_l", gotn_l[4], 3);
    chk("t4_data_m", got_m[4], {16'hA5A5, 16'h1234, 16'hBEEF, 80'h0});
    chk("t4_lanes_m", gotn_m[4], 3);
    pulse_flush();
    step(10);
    chk("t4_empty_flush", n_l, 5);

    // Flush in the same cycle as a read: the in-flight word joins the beat
    push(16'h0042);
    pulse_flush();
    wait_beats(6, "inflight_beat");
    chk("inflight_data", got_l[5], 128'h42);
    chk("inflight_lanes", gotn_l[5], 1);

    // Gap in the upstream stream
    for (int i = 0; i < 4; i++) push(16'(i));
    step(8);
    for (int i = 0; i < 5; i++) begin
      chk("t5_gap_enable", enable_l, 0);
      step(1);
    end
    for (int i = 4; i < 8; i++) push(16'(i));
    wait_beats(7, "t5_beat");
    chk("t5_data_l", got_l[6], 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Reset mid-packet, then a clean stream
    for (int i = 0; i < 5; i++) push(16'(i));
    step(8);
    rst_n = 1'b0;
    #2;
    chk("t6_valid", valid_l, 0);
    chk("t6_enable", enable_l, 0);
    chk("t6_lanes", lanes_l, 0);
    chk("t6_data", dout_l, 0);
    step(2);
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) push(16'(i));
    wait_beats(8, "t6_beat");
    chk("t6_data_l", got_l[7], 128'h000f_000e_000d_000c_000b_000a_0009_0008);
    chk("t6_lanes_l", gotn_l[7], 8);

    step(5);
    chk("drained_l", exp_l.size(), 0);
    chk("drained_m", exp_m.size(), 0);
    chk("no_leftover", pkt.size(), 0);
`ifdef PACKER_STATS_EN
    // Counters restarted at the mid-test reset: only the final beat counts.
    chk("beat_cnt", beat_cnt_l, 1);
    chk("stall_cnt", stall_cnt_l, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
